// File: rtl/kyber_pkg.sv
// rtl/kyber_pkg.sv - shared ML-KEM constants and types for the butterfly datapath
// Purpose: constants (modulus, Montgomery inverse, Barrett factor, latency),
//          the signed coefficient type and a sign-extension helper.
// Ports:   none (package).
package kyber_pkg;

   localparam int KYBER_Q     = 3329;
   localparam int KYBER_QINV  = -3327;
   localparam int BARRETT_V   = 20159;
   localparam int BFU_LATENCY = 4;

   typedef logic signed [15:0] coeff_t;

   // Explicit 16->32 sign extension ahead of every multiply
   function automatic logic signed [31:0] sext16(input coeff_t x);
      return {{16{x[15]}}, x};
   endfunction

endpackage

// File: rtl/kyber_bfu_if.sv
// rtl/kyber_bfu_if.sv - data bus of one butterfly lane
// Purpose: groups mode, operand, twiddle and result signals of a BFU lane.
// Signals: i_intt (mode), i_a / i_b (coefficients), i_twiddle (Montgomery zeta),
//          o_a / o_b (results).
// Modports: master drives operands and reads results; slave is the BFU side.
interface kyber_bfu_if;
   import kyber_pkg::*;

   logic   i_intt;
   coeff_t i_a;
   coeff_t i_b;
   coeff_t i_twiddle;
   coeff_t o_a;
   coeff_t o_b;

   modport master (output i_intt, i_a, i_b, i_twiddle, input o_a, o_b);
   modport slave  (input i_intt, i_a, i_b, i_twiddle, output o_a, o_b);

endinterface

// File: rtl/kyber_mont_reduce.sv
// rtl/kyber_mont_reduce.sv - pipelined 32-to-16-bit Montgomery reduction
// Purpose: first half registers the product and t = lo16(p*QINV); second half
//          is combinational (p - t*Q) >>> 16, registered by the caller.
// Ports:   i_clk, i_rst (async, active-high), i_p (32-bit signed product),
//          o_r (reduced value, congruent to p*2^-16, in (-q, q)).
module kyber_mont_reduce
   import kyber_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic signed [31:0] i_p,
   output coeff_t             o_r
);

   logic signed [31:0] w_pq;
   coeff_t             w_t;
   logic signed [31:0] w_tq;
   logic signed [31:0] w_diff;
   logic signed [31:0] r_p;
   coeff_t             r_t;

   // Only the low 16 bits of p*QINV matter, so a 32-bit wrap is harmless
   assign w_pq = i_p * KYBER_QINV;
   assign w_t  = coeff_t'(w_pq);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_p <= '0;
         r_t <= '0;
      end else begin
         r_p <= i_p;
         r_t <= w_t;
      end
   end

   // Low 16 bits of w_diff are zero by construction; keep the high half
   assign w_tq   = sext16(r_t) * KYBER_Q;
   assign w_diff = r_p - w_tq;
   assign o_r    = coeff_t'(w_diff >>> 16);

endmodule

// File: rtl/kyber_bfu.sv
// rtl/kyber_bfu.sv - 4-stage radix-2 CT/GS butterfly for the ML-KEM NTT
// Purpose: CT: a' = a + fqmul(b,z), b' = a - fqmul(b,z) (no reduction).
//          GS: a' = barrett(a + b), b' = fqmul(b - a, z).
//          Mode travels with its sample, one sample per cycle, no stalls.
// Ports:   i_clk, i_rst (async, active-high), bus (kyber_bfu_if.slave).
module kyber_bfu
   import kyber_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst,
   kyber_bfu_if.slave      bus
);

   // S1: operands; the multiplier operand is b (CT) or b - a (GS)
   logic   r1_intt;
   coeff_t r1_a, r1_sum, r1_mop, r1_tw;
   // S2: full product
   logic               r2_intt;
   coeff_t             r2_a, r2_sum;
   logic signed [31:0] r2_prod;
   // S3: Barrett quotient (Montgomery t lives in the sub-module)
   logic   r3_intt;
   coeff_t r3_a, r3_sum, r3_k;
   // S4: results
   coeff_t r_o_a, r_o_b;

   coeff_t             w_sum, w_diff, w_mont, w_bar;
   logic signed [31:0] w_bv, w_kq;

   assign w_sum  = bus.i_a + bus.i_b;
   assign w_diff = bus.i_b - bus.i_a;

   // Barrett: k = (v*x + 2^25) >>> 26
   assign w_bv = sext16(r2_sum) * BARRETT_V + 32'sd33554432;
   assign w_kq = sext16(r3_k) * KYBER_Q;
   assign w_bar = r3_sum - coeff_t'(w_kq);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r1_intt <= 1'b0;
         r1_a    <= '0;
         r1_sum  <= '0;
         r1_mop  <= '0;
         r1_tw   <= '0;
         r2_intt <= 1'b0;
         r2_a    <= '0;
         r2_sum  <= '0;
         r2_prod <= '0;
         r3_intt <= 1'b0;
         r3_a    <= '0;
         r3_sum  <= '0;
         r3_k    <= '0;
         r_o_a   <= '0;
         r_o_b   <= '0;
      end else begin
         r1_intt <= bus.i_intt;
         r1_a    <= bus.i_a;
         r1_sum  <= w_sum;
         r1_mop  <= bus.i_intt ? w_diff : bus.i_b;
         r1_tw   <= bus.i_twiddle;

         r2_intt <= r1_intt;
         r2_a    <= r1_a;
         r2_sum  <= r1_sum;
         r2_prod <= sext16(r1_mop) * sext16(r1_tw);

         r3_intt <= r2_intt;
         r3_a    <= r2_a;
         r3_sum  <= r2_sum;
         r3_k    <= coeff_t'(w_bv >>> 26);

         if (r3_intt) begin
            r_o_a <= w_bar;
            r_o_b <= w_mont;
         end else begin
            r_o_a <= r3_a + w_mont;
            r_o_b <= r3_a - w_mont;
         end
      end
   end

   kyber_mont_reduce u_mont (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_p   (r2_prod),
      .o_r   (w_mont)
   );

   assign bus.o_a = r_o_a;
   assign bus.o_b = r_o_b;

endmodule

// File: tb/tb_kyber_bfu.sv
// tb/tb_kyber_bfu.sv - scoreboard bench for kyber_bfu
module tb_kyber_bfu;

   typedef struct {
      int         id;
      logic [15:0] a;
      logic [15:0] b;
   } exp_t;

   logic clk;
   logic rst;
   int   n_total;
   int   n_bad;
   int   n_id;
   exp_t exp_q[$];

   kyber_bfu_if bus();

   kyber_bfu dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [15:0] m_mont(input int p);
      int t32;
      int t;
      int r;
      t32 = p * -3327;
      t   = {{16{t32[15]}}, t32[15:0]};
      r   = (p - t * 3329) >>> 16;
      return r[15:0];
   endfunction

   function automatic logic [15:0] m_fqmul(input logic [15:0] x, input logic [15:0] z);
      int xi;
      int zi;
      xi = int'($signed(x));
      zi = int'($signed(z));
      return m_mont(xi * zi);
   endfunction

   function automatic logic [15:0] m_barrett(input logic [15:0] x);
      int xi;
      int k;
      int r;
      xi = int'($signed(x));
      k  = (20159 * xi + 33554432) >>> 26;
      r  = xi - k * 3329;
      return r[15:0];
   endfunction

   task automatic model(input logic intt, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] tw, output logic [15:0] ea, output logic [15:0] eb);
      logic [15:0] t;
      logic [15:0] s;
      logic [15:0] d;
      if (!intt) begin
         t  = m_fqmul(b, tw);
         ea = a + t;
         eb = a - t;
      end else begin
         s  = a + b;
         d  = b - a;
         ea = m_barrett(s);
         eb = m_fqmul(d, tw);
      end
   endtask

   task automatic pop_check();
      exp_t e;
      e = exp_q.pop_front();
      chk($sformatf("o_a#%0d", e.id), bus.o_a, e.a);
      chk($sformatf("o_b#%0d", e.id), bus.o_b, e.b);
   endtask

   task automatic step(input logic intt, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] tw, input logic [15:0] ea, input logic [15:0] eb);
      @(negedge clk);
      if (exp_q.size() >= 4) pop_check();
      bus.i_intt    = intt;
      bus.i_a       = a;
      bus.i_b       = b;
      bus.i_twiddle = tw;
      exp_q.push_back('{n_id, ea, eb});
      n_id++;
   endtask

   // Pipeline holds zeros after reset; the input at the release edge is zero too
   task automatic release_reset();
      @(negedge clk);
      rst           = 1'b0;
      bus.i_intt    = 1'b0;
      bus.i_a       = '0;
      bus.i_b       = '0;
      bus.i_twiddle = '0;
      exp_q.delete();
      repeat (4) begin
         exp_q.push_back('{-1, 16'h0000, 16'h0000});
      end
   endtask

   task automatic reset_mid();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_o_a", bus.o_a, 16'h0000);
      chk("async_rst_o_b", bus.o_b, 16'h0000);
      release_reset();
   endtask

   logic        r_intt;
   logic [15:0] r_a, r_b, r_tw, r_ea, r_eb;

   initial begin
      n_total = 0;
      n_bad   = 0;
      n_id    = 0;
      rst           = 1'b1;
      bus.i_intt    = 1'b0;
      bus.i_a       = 16'h1234;
      bus.i_b       = 16'h5678;
      bus.i_twiddle = 16'h0abc;
      repeat (3) @(negedge clk);
      chk("reset_o_a", bus.o_a, 16'h0000);
      chk("reset_o_b", bus.o_b, 16'h0000);
      release_reset();

      // Directed vectors, back-to-back with alternating mode
      step(1'b0, 16'd5,     16'd1000, 16'd2285, 16'd1005, 16'hFC1D);
      step(1'b1, 16'd100,   16'd300,  16'd2285, 16'd400,  16'd200);
      step(1'b0, 16'd32767, 16'd1,    16'd2285, 16'h8000, 16'd32766);
      step(1'b1, 16'd3000,  16'd3000, 16'd1441, 16'hFD6E, 16'd0);

      // Final INTT scaling form and extreme operands
      r_b = 16'd1234;
      model(1'b0, 16'd0, r_b, 16'd1441, r_ea, r_eb);
      step(1'b0, 16'd0, r_b, 16'd1441, r_ea, r_eb);
      model(1'b1, 16'h8000, 16'h8000, 16'h7FFF, r_ea, r_eb);
      step(1'b1, 16'h8000, 16'h8000, 16'h7FFF, r_ea, r_eb);
      model(1'b0, 16'h7FFF, 16'h8000, 16'h8000, r_ea, r_eb);
      step(1'b0, 16'h7FFF, 16'h8000, 16'h8000, r_ea, r_eb);

      for (int n = 0; n < 10000; n++) begin
         if (n == 5000) reset_mid();
         r_intt = 1'($urandom_range(0, 1));
         r_a    = 16'($urandom);
         r_b    = 16'($urandom);
         r_tw   = 16'($urandom);
         model(r_intt, r_a, r_b, r_tw, r_ea, r_eb);
         step(r_intt, r_a, r_b, r_tw, r_ea, r_eb);
      end

      repeat (4) begin
         @(negedge clk);
         pop_check();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
